// File: rtl/framing_classifier_pkg.sv
// Shared definitions for the framing classifier: the K-symbol token values,
// the per-lane byte-type codes reported on byte_type, and the packet state
// that is carried from lane to lane and from cycle to cycle.
package framing_classifier_pkg;

   // K-symbol tokens; these only mean anything when the lane's dk flag is set
   localparam logic [7:0] TOK_STP = 8'hFB;
   localparam logic [7:0] TOK_SDP = 8'h5C;
   localparam logic [7:0] TOK_END = 8'hFD;
   localparam logic [7:0] TOK_EDB = 8'hFE;
   localparam logic [7:0] TOK_PAD = 8'hF7;

   // Per-lane classification codes (3 bits per lane on byte_type)
   localparam logic [2:0] BT_DATA       = 3'b000;
   localparam logic [2:0] BT_TLP_START  = 3'b001;
   localparam logic [2:0] BT_TLP_END    = 3'b010;
   localparam logic [2:0] BT_DLLP_START = 3'b011;
   localparam logic [2:0] BT_DLLP_END   = 3'b100;
   localparam logic [2:0] BT_TLP_EDB    = 3'b101;
   localparam logic [2:0] BT_NOT_VALID  = 3'b111;

   // Width of the packet-state encoding as it travels between lanes
   localparam int STATE_W = 2;

   // Packet state: outside any packet, inside a TLP, or inside a DLLP
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 2'd0,
      ST_IN_TLP  = 2'd1,
      ST_IN_DLLP = 2'd2
   } pkt_state_t;

endpackage

// File: rtl/framing_classifier_lane.sv
// Combinational classifier for a single byte lane. It takes the packet state
// left behind by the previous lane and produces this lane's byte type, the
// state handed to the next lane, a framing-error flag and start-token strobes.
// The top module chains one of these per lane so a whole cycle is walked in
// lane order (lane 0 first in time).
module lane_classifier
   import framing_classifier_pkg::*;
(
   input  logic [7:0]         lane_byte,
   input  logic               dk,
   input  logic               byte_valid,
   input  logic [STATE_W-1:0] state_in,
   output logic [2:0]         lane_type,
   output logic [STATE_W-1:0] state_out,
   output logic               err,
   output logic               is_stp,
   output logic               is_sdp
);

   logic in_idle;
   logic in_tlp;
   logic in_dllp;

   assign in_idle = (state_in == ST_IDLE);
   assign in_tlp  = (state_in == ST_IN_TLP);
   assign in_dllp = (state_in == ST_IN_DLLP);

   // Classify the lane byte against the incoming packet state
   always_comb begin
      lane_type = BT_NOT_VALID;
      state_out = state_in;
      err       = 1'b0;
      is_stp    = 1'b0;
      is_sdp    = 1'b0;

      if (byte_valid) begin
         if (!dk) begin
            // Plain data is only meaningful inside a packet; between
            // packets it is reported as not-valid but is not an error.
            if (!in_idle) begin
               lane_type = BT_DATA;
            end
         end else begin
            // Every K symbol except a start token leaves us outside a packet
            state_out = ST_IDLE;
            case (lane_byte)
               TOK_STP: begin
                  lane_type = BT_TLP_START;
                  state_out = ST_IN_TLP;
                  is_stp    = 1'b1;
                  err       = !in_idle;
               end
               TOK_SDP: begin
                  lane_type = BT_DLLP_START;
                  state_out = ST_IN_DLLP;
                  is_sdp    = 1'b1;
                  err       = !in_idle;
               end
               TOK_END: begin
                  if (in_tlp) begin
                     lane_type = BT_TLP_END;
                  end else if (in_dllp) begin
                     lane_type = BT_DLLP_END;
                  end else begin
                     err = 1'b1;
                  end
               end
               TOK_EDB: begin
                  // EDB only nullifies a TLP; anywhere else it is stray
                  if (in_tlp) begin
                     lane_type = BT_TLP_EDB;
                  end else begin
                     err = 1'b1;
                  end
               end
               TOK_PAD: begin
                  err = !in_idle;
               end
               default: begin
                  err = 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/framing_classifier.sv
// Multi-lane framing classifier. Each cycle the NBYTES lanes are classified
// in order by a chain of lane_classifier instances, starting from the packet
// state left at the end of the previous accepted cycle. Results, a framing
// error pulse and saturating start-token counters are registered so every
// output appears exactly one cycle after its inputs were sampled.
module framing_classifier
   import framing_classifier_pkg::*;
#(
   parameter int NBYTES = 64,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [8*NBYTES-1:0]   data_in,
   input  logic [NBYTES-1:0]     dk,
   input  logic [NBYTES-1:0]     byte_valid,
   output logic                  out_valid,
   output logic [8*NBYTES-1:0]   data_out,
   output logic [3*NBYTES-1:0]   byte_type,
   output logic                  frame_err,
   output logic [CNT_W-1:0]      tlp_cnt,
   output logic [CNT_W-1:0]      dllp_cnt
);

   // Enough bits to hold the number of start tokens in one cycle (0..NBYTES)
   localparam int ADD_W = $clog2(NBYTES + 1);
   // Sum width wide enough that counter + per-cycle count never overflows
   localparam int SUM_W = CNT_W + ADD_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Carried packet state
   pkt_state_t state_reg;
   pkt_state_t state_next;

   // Lane chain signals; chain_state[i] is the state seen by lane i
   logic [NBYTES:0][STATE_W-1:0] chain_state;
   logic [NBYTES-1:0][2:0]       lane_type;
   logic [NBYTES-1:0]            lane_err;
   logic [NBYTES-1:0]            lane_stp;
   logic [NBYTES-1:0]            lane_sdp;

   // Per-cycle start-token counts
   logic [ADD_W-1:0] stp_count;
   logic [ADD_W-1:0] sdp_count;
   logic [SUM_W-1:0] tlp_sum;
   logic [SUM_W-1:0] dllp_sum;

   // Output registers and their next values
   logic                   out_valid_reg;
   logic                   out_valid_next;
   logic [8*NBYTES-1:0]    data_out_reg;
   logic [8*NBYTES-1:0]    data_out_next;
   logic [NBYTES-1:0][2:0] byte_type_reg;
   logic [NBYTES-1:0][2:0] byte_type_next;
   logic                   frame_err_reg;
   logic                   frame_err_next;
   logic [CNT_W-1:0]       tlp_cnt_reg;
   logic [CNT_W-1:0]       tlp_cnt_next;
   logic [CNT_W-1:0]       dllp_cnt_reg;
   logic [CNT_W-1:0]       dllp_cnt_next;

   assign chain_state[0] = state_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NBYTES; gi++) begin : g_lane
         lane_classifier u_lane (
            .lane_byte  (data_in[8*gi +: 8]),
            .dk         (dk[gi]),
            .byte_valid (byte_valid[gi]),
            .state_in   (chain_state[gi]),
            .lane_type  (lane_type[gi]),
            .state_out  (chain_state[gi+1]),
            .err        (lane_err[gi]),
            .is_stp     (lane_stp[gi]),
            .is_sdp     (lane_sdp[gi])
         );
      end
   endgenerate

   // Count the STP and SDP tokens seen across all lanes this cycle
   always_comb begin
      stp_count = '0;
      sdp_count = '0;
      for (int i = 0; i < NBYTES; i++) begin
         stp_count = stp_count + ADD_W'(lane_stp[i]);
         sdp_count = sdp_count + ADD_W'(lane_sdp[i]);
      end
   end

   // Unsaturated counter sums, clamped when the next values are formed
   assign tlp_sum  = SUM_W'(tlp_cnt_reg)  + SUM_W'(stp_count);
   assign dllp_sum = SUM_W'(dllp_cnt_reg) + SUM_W'(sdp_count);

   // Register all state; reset wins over any traffic in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         out_valid_reg <= 1'b0;
         data_out_reg  <= '0;
         byte_type_reg <= '1;
         frame_err_reg <= 1'b0;
         tlp_cnt_reg   <= '0;
         dllp_cnt_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         out_valid_reg <= out_valid_next;
         data_out_reg  <= data_out_next;
         byte_type_reg <= byte_type_next;
         frame_err_reg <= frame_err_next;
         tlp_cnt_reg   <= tlp_cnt_next;
         dllp_cnt_reg  <= dllp_cnt_next;
      end
   end

   // Next packet state: take the end of the lane chain only on accepted cycles
   always_comb begin
      state_next = state_reg;
      if (in_valid) begin
         state_next = pkt_state_t'(chain_state[NBYTES]);
      end
   end

   // Next output values: idle cycles hold the last report and never flag errors
   always_comb begin
      out_valid_next = in_valid;
      data_out_next  = data_out_reg;
      byte_type_next = byte_type_reg;
      frame_err_next = 1'b0;
      tlp_cnt_next   = tlp_cnt_reg;
      dllp_cnt_next  = dllp_cnt_reg;
      if (in_valid) begin
         data_out_next  = data_in;
         byte_type_next = lane_type;
         frame_err_next = |lane_err;
         if (tlp_sum > SUM_W'(CNT_MAX)) begin
            tlp_cnt_next = CNT_MAX;
         end else begin
            tlp_cnt_next = tlp_sum[CNT_W-1:0];
         end
         if (dllp_sum > SUM_W'(CNT_MAX)) begin
            dllp_cnt_next = CNT_MAX;
         end else begin
            dllp_cnt_next = dllp_sum[CNT_W-1:0];
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign data_out  = data_out_reg;
   assign byte_type = byte_type_reg;
   assign frame_err = frame_err_reg;
   assign tlp_cnt   = tlp_cnt_reg;
   assign dllp_cnt  = dllp_cnt_reg;

endmodule

// File: doc/framing_classifier.md
FRAMING_CLASSIFIER -- requirements
Module: framing_classifier

Interface
REQ-001 SHALL have parameter NBYTES, default 64, meaning byte lanes per cycle (1..64).
REQ-002 SHALL have parameter CNT_W, default 16, meaning packet-counter width.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 in_valid  in  1  cycle qualifier for all lane inputs.
REQ-006 data_in  in  8*NBYTES  lane bytes; lane i = bits 8i+7:8i; lane 0 is first in time.
REQ-007 dk  in  NBYTES  per-lane K-symbol flag.
REQ-008 byte_valid  in  NBYTES  per-lane valid.
REQ-009 out_valid  out  1  registered in_valid.
REQ-010 data_out  out  8*NBYTES  registered data_in.
REQ-011 byte_type  out  3*NBYTES  per-lane class: 000 data, 001 tlpstart, 010 tlpend, 011 dllpstart, 100 dllpend, 101 tlpedb, 111 not_valid.
REQ-012 frame_err  out  1  one-cycle pulse; a framing violation occurred in the reported cycle.
REQ-013 tlp_cnt / dllp_cnt  out  CNT_W each  saturating count of STP / SDP tokens since reset.

Function
REQ-014 Tokens, valid only with dk=1: STP 0xFB, SDP 0x5C, END 0xFD, EDB 0xFE, PAD 0xF7.
REQ-015 Packet state SHALL be one of IDLE, IN_TLP, IN_DLLP, walked lane 0 to NBYTES-1 within a cycle and carried across cycles.
REQ-016 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on all outputs after edge N.
REQ-017 When in_valid=0: out_valid=0 next cycle; data_out, byte_type, state and counters hold; frame_err=0.
REQ-018 byte_valid=0 lane: type 111; state unchanged; no error.
REQ-019 dk=0 lane: type 000 if state is not IDLE, else 111 with no error.
REQ-020 STP: type 001; state -> IN_TLP; tlp_cnt +1; error if state was not IDLE.
REQ-021 SDP: type 011; state -> IN_DLLP; dllp_cnt +1; error if state was not IDLE.
REQ-022 END: 010 from IN_TLP, 100 from IN_DLLP; from IDLE, type 111 plus error; state -> IDLE.
REQ-023 EDB: 101 from IN_TLP; otherwise type 111 plus error; state -> IDLE.
REQ-024 PAD: type 111; error if state is not IDLE; state -> IDLE.
REQ-025 Any other dk=1 byte: type 111; error; state -> IDLE.
REQ-026 Counters SHALL add the number of start tokens in the cycle (0..NBYTES) and saturate at 2^CNT_W-1, never wrap.
REQ-027 frame_err SHALL be the OR of all lane errors in the cycle.

Reset
REQ-028 On rst=1 at a clock edge: state IDLE, out_valid 0, data_out 0, byte_type all ones, frame_err 0, counters 0.
REQ-029 Reset SHALL override in_valid in the same cycle; a packet open at reset is discarded with no error.

Structure
REQ-030 Shared package SHALL hold the token constants, byte-type codes and the state enum.
REQ-031 One combinational sub-module lane_classifier (byte, dk, byte_valid, state_in -> type, state_out, err, is_stp, is_sdp) SHALL be chained NBYTES times.
REQ-032 All outputs SHALL be driven from registers.

Verification
REQ-033 Bench SHALL drive lane0 STP dk=1, lanes1-3 0x08 dk=0, lanes4-63 byte_valid=0 -> next cycle: lane0 001, lanes1-3 000, rest 111, tlp_cnt=1, frame_err=0.
REQ-034 Bench SHALL drive lane0 0x08 dk=0, lane1 END, lane2 SDP, lane3 data, lane4 END in one cycle -> 000,010,011,000,100; dllp_cnt=1.
REQ-035 Bench SHALL drive SDP at lane63 in cycle N, all-data cycle N+1 and END at lane5 in cycle N+2 -> N+1 all 000; N+2 lanes0-4 000, lane5 100, lanes6-63 111.
REQ-036 Bench SHALL drive END from IDLE -> 111 and frame_err=1 for one cycle; EDB inside TLP -> 101; STP inside TLP -> 001 with frame_err=1.
REQ-037 Bench SHALL assert rst mid-TLP, then drive dk=0 data -> all 111, counters 0, frame_err 0.
REQ-038 Bench SHALL use CNT_W=2 with 5 STP/END pairs -> tlp_cnt saturates at 3.
